// File: rtl/fp_addsub_seq_if.sv
// Handshake and status/strobe bundle between the FP add/sub sequencer and
// the multi-cycle controller plus datapath registers.
// Optional feature macro: FAST_ALIGN_EN (adds the align_flush strobe).
interface fp_addsub_seq_if #(
   parameter int MSB_W = 5
);
   // controller handshake
   logic             start;
   logic             busy;
   logic             done;
   // datapath status
   logic             special;
   logic [7:0]       exp_diff;
   logic             sum_zero;
   logic [MSB_W-1:0] msb_loc;
   logic             round_carry;
   // datapath strobes
   logic             ld_ops;
   logic             align_shift;
`ifdef FAST_ALIGN_EN
   logic             align_flush;
`endif
   logic             add_en;
   logic             norm_right;
   logic             norm_left;
   logic             round_en;
   logic             renorm_en;
   logic             pack_en;
   logic [1:0]       res_sel;

   // controller/datapath side: drives start and status, observes strobes
   modport master (
      output start, special, exp_diff, sum_zero, msb_loc, round_carry,
`ifdef FAST_ALIGN_EN
      input  align_flush,
`endif
      input  busy, done, ld_ops, align_shift, add_en, norm_right, norm_left,
             round_en, renorm_en, pack_en, res_sel
   );

   // sequencer side
   modport slave (
      input  start, special, exp_diff, sum_zero, msb_loc, round_carry,
`ifdef FAST_ALIGN_EN
      output align_flush,
`endif
      output busy, done, ld_ops, align_shift, add_en, norm_right, norm_left,
             round_en, renorm_en, pack_en, res_sel
   );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle control FSM for the floating-point add/sub datapath:
// unpack, align, add, normalize, round, renormalize, pack.
// Owns the alignment (acnt) and normalization (ncnt) shift counters and
// issues one-cycle enable strobes; it never sees mantissa data.
// Optional feature macro: FAST_ALIGN_EN. When defined, an exponent
// difference at or above MAX_ALIGN takes a single ALIGN cycle that pulses
// align_flush (mantissa collapsed to sticky) instead of MAX_ALIGN shifts.
module fp_addsub_seq #(
   parameter int MAX_ALIGN   = 27,
   parameter int NORM_TARGET = 26,
   parameter int MSB_W       = 5
) (
   input logic          clk,
   input logic          rst_n,
   fp_addsub_seq_if.slave bus
);
   localparam int ACNT_W = $clog2(MAX_ALIGN + 1);
   localparam int NCNT_W = $clog2(NORM_TARGET + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NCHK,
      S_NORM_R,
      S_NORM_L,
      S_ROUND,
      S_RCHK,
      S_PACK,
      S_DONE
   } state_t;

   state_t              state_reg;
   logic [ACNT_W-1:0]   acnt_reg;
   logic [NCNT_W-1:0]   ncnt_reg;
   logic [1:0]          res_sel_reg;
   logic                busy_reg;
   logic                align_shift_reg;
   logic                add_en_reg;
   logic                norm_right_reg;
   logic                norm_left_reg;
   logic                round_en_reg;
   logic                pack_en_reg;
   logic                done_reg;
`ifdef FAST_ALIGN_EN
   logic                flush_reg;
`endif

   // Decoded status from the datapath; only consulted in the state where
   // each input is defined to be valid.
   logic                wide_diff;
   logic [ACNT_W-1:0]   acnt_start;
   logic                msb_high;
   logic                msb_on_target;
   logic [NCNT_W-1:0]   ncnt_start;

   // Clamp alignment count and classify the leading-one position.
   always_comb begin
      wide_diff     = (bus.exp_diff >= 8'(MAX_ALIGN));
      acnt_start    = wide_diff ? ACNT_W'(MAX_ALIGN) : ACNT_W'(bus.exp_diff);
      // values above NORM_TARGET+1 are treated like NORM_TARGET+1
      msb_high      = (bus.msb_loc >= MSB_W'(NORM_TARGET + 1));
      msb_on_target = (bus.msb_loc == MSB_W'(NORM_TARGET));
      ncnt_start    = NCNT_W'(NORM_TARGET) - NCNT_W'(bus.msb_loc);
   end

   // Sequencer: state, counters and registered strobes. Each strobe is set
   // on the edge that enters the state it belongs to, so it is high for
   // exactly the cycles spent in that state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         acnt_reg        <= '0;
         ncnt_reg        <= '0;
         res_sel_reg     <= 2'd0;
         busy_reg        <= 1'b0;
         align_shift_reg <= 1'b0;
         add_en_reg      <= 1'b0;
         norm_right_reg  <= 1'b0;
         norm_left_reg   <= 1'b0;
         round_en_reg    <= 1'b0;
         pack_en_reg     <= 1'b0;
         done_reg        <= 1'b0;
`ifdef FAST_ALIGN_EN
         flush_reg       <= 1'b0;
`endif
      end else begin
         align_shift_reg <= 1'b0;
         add_en_reg      <= 1'b0;
         norm_right_reg  <= 1'b0;
         norm_left_reg   <= 1'b0;
         round_en_reg    <= 1'b0;
         pack_en_reg     <= 1'b0;
         done_reg        <= 1'b0;
`ifdef FAST_ALIGN_EN
         flush_reg       <= 1'b0;
`endif
         case (state_reg)
            S_IDLE: begin
               if (bus.start) begin
                  state_reg <= S_UNPACK;
                  busy_reg  <= 1'b1;
               end
            end
            S_UNPACK: begin
               if (bus.special) begin
                  state_reg   <= S_PACK;
                  res_sel_reg <= 2'd1;
                  pack_en_reg <= 1'b1;
               end else if (acnt_start == '0) begin
                  state_reg  <= S_ADD;
                  add_en_reg <= 1'b1;
               end else begin
                  state_reg <= S_ALIGN;
`ifdef FAST_ALIGN_EN
                  if (wide_diff) begin
                     // one flush cycle replaces the full shift sequence
                     acnt_reg  <= ACNT_W'(1);
                     flush_reg <= 1'b1;
                  end else begin
                     acnt_reg        <= acnt_start;
                     align_shift_reg <= 1'b1;
                  end
`else
                  acnt_reg        <= acnt_start;
                  align_shift_reg <= 1'b1;
`endif
               end
            end
            S_ALIGN: begin
               acnt_reg <= acnt_reg - ACNT_W'(1);
               if (acnt_reg == ACNT_W'(1)) begin
                  state_reg  <= S_ADD;
                  add_en_reg <= 1'b1;
               end else begin
                  align_shift_reg <= 1'b1;
               end
            end
            S_ADD: begin
               state_reg <= S_NCHK;
            end
            S_NCHK: begin
               if (bus.sum_zero) begin
                  state_reg   <= S_PACK;
                  res_sel_reg <= 2'd2;
                  pack_en_reg <= 1'b1;
               end else if (msb_high) begin
                  state_reg      <= S_NORM_R;
                  norm_right_reg <= 1'b1;
               end else if (msb_on_target) begin
                  state_reg    <= S_ROUND;
                  round_en_reg <= 1'b1;
               end else begin
                  state_reg     <= S_NORM_L;
                  ncnt_reg      <= ncnt_start;
                  norm_left_reg <= 1'b1;
               end
            end
            S_NORM_R: begin
               state_reg    <= S_ROUND;
               round_en_reg <= 1'b1;
            end
            S_NORM_L: begin
               ncnt_reg <= ncnt_reg - NCNT_W'(1);
               if (ncnt_reg == NCNT_W'(1)) begin
                  state_reg    <= S_ROUND;
                  round_en_reg <= 1'b1;
               end else begin
                  norm_left_reg <= 1'b1;
               end
            end
            S_ROUND: begin
               state_reg <= S_RCHK;
            end
            S_RCHK: begin
               state_reg   <= S_PACK;
               pack_en_reg <= 1'b1;
            end
            S_PACK: begin
               state_reg <= S_DONE;
               done_reg  <= 1'b1;
            end
            S_DONE: begin
               state_reg   <= S_IDLE;
               busy_reg    <= 1'b0;
               res_sel_reg <= 2'd0;
            end
            default: begin
               state_reg   <= S_IDLE;
               busy_reg    <= 1'b0;
               res_sel_reg <= 2'd0;
            end
         endcase
      end
   end

   // ld_ops and renorm_en follow their inputs within the same cycle, so
   // they are decoded from the current state rather than registered.
   assign bus.ld_ops      = rst_n & bus.start & (state_reg == S_IDLE);
   assign bus.renorm_en   = bus.round_carry & (state_reg == S_RCHK);

   assign bus.busy        = busy_reg;
   assign bus.align_shift = align_shift_reg;
   assign bus.add_en      = add_en_reg;
   assign bus.norm_right  = norm_right_reg;
   assign bus.norm_left   = norm_left_reg;
   assign bus.round_en    = round_en_reg;
   assign bus.pack_en     = pack_en_reg;
   assign bus.res_sel     = res_sel_reg;
   assign bus.done        = done_reg;
`ifdef FAST_ALIGN_EN
   assign bus.align_flush = flush_reg;
`endif
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq. Each transaction is summarised as
// strobe counts, done cycle and pack source, and compared with a model
// computed from the operation's rules. Honours FAST_ALIGN_EN.
module tb_fp_addsub_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_addsub_seq_if #(.MSB_W(5)) bus ();

   fp_addsub_seq #(.MAX_ALIGN(27), .NORM_TARGET(26), .MSB_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef FAST_ALIGN_EN
   localparam bit FAST = 1'b1;
   wire fl = bus.align_flush;
`else
   localparam bit FAST = 1'b0;
   wire fl = 1'b0;
`endif

   wire [12:0] all_out = {bus.ld_ops, bus.busy, bus.align_shift, bus.add_en,
                          bus.norm_right, bus.norm_left, bus.round_en,
                          bus.renorm_en, bus.pack_en, bus.res_sel, bus.done, fl};

   typedef struct packed {
      logic [7:0] ld0;
      logic [7:0] ld_busy;
      logic [7:0] align;
      logic [7:0] flush;
      logic [7:0] add;
      logic [7:0] nr;
      logic [7:0] nl;
      logic [7:0] rnd;
      logic [7:0] ren;
      logic [7:0] pack;
      logic [7:0] res;
      logic [7:0] busy;
      logic [7:0] ndone;
      logic [7:0] done_cyc;
   } obs_t;

   obs_t obs;
   obs_t exp_o;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Expected summary of one operation, from the latency and strobe rules.
   function automatic obs_t model(input bit sp, input int ed, input bit sz,
                                  input int msb, input bit rc);
      obs_t e;
      int   d, m, nr, nl, dc;
      bit   flushy;
      e = '0;
      e.ld0   = 8'd1;
      e.ndone = 8'd1;
      e.pack  = 8'd1;
      if (sp) begin
         e.res      = 8'd1;
         e.done_cyc = 8'd3;
         e.busy     = 8'd3;
         return e;
      end
      flushy  = FAST && (ed >= 27);
      d       = flushy ? 1 : ((ed > 27) ? 27 : ed);
      e.align = flushy ? 8'd0 : 8'(d);
      e.flush = flushy ? 8'd1 : 8'd0;
      e.add   = 8'd1;
      if (sz) begin
         e.res = 8'd2;
         dc    = d + 5;
      end else begin
         m     = (msb > 27) ? 27 : msb;
         nr    = (m == 27) ? 1 : 0;
         nl    = (m < 26) ? 26 - m : 0;
         e.nr  = 8'(nr);
         e.nl  = 8'(nl);
         e.rnd = 8'd1;
         e.ren = rc ? 8'd1 : 8'd0;
         e.res = 8'd0;
         dc    = d + nr + nl + 7;
      end
      e.done_cyc = 8'(dc);
      e.busy     = 8'(dc);
      return e;
   endfunction

   // Accumulate the DUT outputs of one cycle into obs.
   task automatic sample(input int cyc);
      if (cyc == 0) obs.ld0 = 8'(bus.ld_ops);
      else          obs.ld_busy = obs.ld_busy + 8'(bus.ld_ops);
      obs.align = obs.align + 8'(bus.align_shift);
      obs.flush = obs.flush + 8'(fl);
      obs.add   = obs.add + 8'(bus.add_en);
      obs.nr    = obs.nr + 8'(bus.norm_right);
      obs.nl    = obs.nl + 8'(bus.norm_left);
      obs.rnd   = obs.rnd + 8'(bus.round_en);
      obs.ren   = obs.ren + 8'(bus.renorm_en);
      obs.pack  = obs.pack + 8'(bus.pack_en);
      obs.busy  = obs.busy + 8'(bus.busy);
      if (bus.pack_en) obs.res = 8'(bus.res_sel);
      if (bus.done) begin
         obs.ndone    = obs.ndone + 8'd1;
         obs.done_cyc = 8'(cyc);
      end
   endtask

   // Issue one operation and observe it until done (bounded by 150 cycles).
   task automatic run_txn(input bit sp, input int ed, input bit sz,
                          input int msb, input bit rc, input bit noisy);
      int cyc;
      obs = '0;
      @(negedge clk);
      bus.special     = sp;
      bus.exp_diff    = 8'(ed);
      bus.sum_zero    = sz;
      bus.msb_loc     = 5'(msb);
      bus.round_carry = rc;
      bus.start       = 1'b1;
      #1;
      cyc = 0;
      sample(cyc);
      while (obs.ndone == 8'd0 && cyc < 150) begin
         @(negedge clk);
         cyc++;
         bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         sample(cyc);
      end
      bus.start = 1'b0;
      exp_o = model(sp, ed, sz, msb, rc);
      $display("txn sp=%0d ed=%0d sz=%0d msb=%0d rc=%0d noisy=%0d -> done at %0d",
               sp, ed, sz, msb, rc, noisy, obs.done_cyc);
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.special = 1'b0; bus.exp_diff = 8'd0;
      bus.sum_zero = 1'b0; bus.msb_loc = 5'd0; bus.round_carry = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (all_out !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 0", all_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (all_out !== 13'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b required 0", all_out);
      end
   endtask

   task automatic test_scenario(input string name, input bit sp, input int ed,
                                input bit sz, input int msb, input bit rc,
                                input bit noisy);
      run_txn(sp, ed, sz, msb, rc, noisy);
      n_checks++;
      if (obs !== exp_o) begin
         n_fail++;
         $display("FAIL %s: got %p required %p", name, obs, exp_o);
      end
      // one cycle after done the sequencer must be idle with nothing queued
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.busy, bus.res_sel, bus.done} !== 4'd0) begin
         n_fail++;
         $display("FAIL %s_idle: got busy/res_sel/done %b required 0",
                  name, {bus.busy, bus.res_sel, bus.done});
      end
   endtask

   task automatic test_reset_mid_align();
      bit saw_done;
      @(negedge clk);
      bus.special = 1'b0; bus.exp_diff = 8'd20; bus.sum_zero = 1'b0;
      bus.msb_loc = 5'd26; bus.round_carry = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.align_shift !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_align_state: align_shift got %b required 1", bus.align_shift);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (all_out !== 13'd0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got %b required 0", all_out);
      end
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done: got %b required 0", saw_done);
      end
      rst_n = 1'b1;
      test_scenario("after_reset", 1'b0, 4, 1'b0, 24, 1'b1, 1'b0);
   endtask

   task automatic test_random(input int count, input bit noisy);
      for (int i = 0; i < count; i++) begin
         bit sp, sz, rc;
         int ed, msb;
         sp  = ($urandom_range(0, 7) == 0);
         sz  = ($urandom_range(0, 7) == 0);
         rc  = 1'($urandom_range(0, 1));
         msb = $urandom_range(0, 31);
         case ($urandom_range(0, 3))
            0:       ed = 0;
            1:       ed = $urandom_range(25, 255);
            default: ed = $urandom_range(1, 30);
         endcase
         run_txn(sp, ed, sz, msb, rc, noisy);
         n_checks++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL random_%0d: got %p required %p", i, obs, exp_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scenario("special",      1'b1,   9, 1'b0, 26, 1'b0, 1'b0);
      test_scenario("align3",       1'b0,   3, 1'b0, 26, 1'b0, 1'b0);
      test_scenario("norm_right",   1'b0,   0, 1'b0, 27, 1'b1, 1'b0);
      test_scenario("norm_left",    1'b0,   1, 1'b0, 20, 1'b0, 1'b0);
      test_scenario("zero_sum",     1'b0,   2, 1'b1, 13, 1'b1, 1'b0);
      test_scenario("msb_clamp",    1'b0,   5, 1'b0, 31, 1'b0, 1'b0);
      test_scenario("msb_zero",     1'b0,   0, 1'b0,  0, 1'b1, 1'b0);
      test_scenario("wide_align",   1'b0, 200, 1'b0, 26, 1'b0, 1'b0);
      test_scenario("edge_align27", 1'b0,  27, 1'b0, 25, 1'b0, 1'b0);
      test_scenario("edge_align26", 1'b0,  26, 1'b0, 26, 1'b1, 1'b0);
      test_scenario("busy_ignore",  1'b0,   5, 1'b0, 22, 1'b1, 1'b1);
      test_reset_mid_align();
      test_random(30, 1'b0);
      test_random(15, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle control FSM for the floating-point add/sub datapath: unpack, align, add, normalize, round, renormalize, pack.
- Sits between the core's multi-cycle controller (start/done handshake) and the FP datapath registers.
- Drives one-cycle enable strobes and owns the alignment and normalization shift counters.
- Samples status from the datapath; holds no mantissa data.

Parameters:
- MAX_ALIGN, 27, alignment shift count clamp (mantissa width incl. guard bits minus 1).
- NORM_TARGET, 26, msb_loc position of the hidden bit after normalization.
- MSB_W, 5, width of msb_loc.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- special  in  1  NaN/Inf/zero operand detected; valid in UNPACK.
- exp_diff  in  8  |expA-expB|; valid in UNPACK.
- sum_zero  in  1  post-add mantissa is zero; valid in NCHK.
- msb_loc  in  MSB_W  leading-one index of 28-bit sum; valid in NCHK.
- round_carry  in  1  rounded mantissa overflowed (bit 24); valid in RCHK.
- busy  out  1  high from the cycle after start is accepted through DONE inclusive.
- ld_ops  out  1  load operand registers.
- align_shift  out  1  shift smaller mantissa right 1 with sticky.
- add_en  out  1  register the sum.
- norm_right  out  1  right-shift 1, exponent+1.
- norm_left  out  1  left-shift 1, exponent-1.
- round_en  out  1  register the rounded mantissa.
- renorm_en  out  1  right-shift 1 after round carry, exponent+1.
- pack_en  out  1  register the packed result.
- res_sel  out  2  pack source: 0 normal, 1 special, 2 zero.
- done  out  1  one-cycle pulse; result register valid.

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately, with no done pulse.
- Strobes are decoded from state, one cycle each.
- IDLE:
  - ld_ops = start.
  - On start, go to UNPACK.
- UNPACK:
  - special → PACK with res_sel latched to 1.
  - Otherwise acnt = min(exp_diff, MAX_ALIGN).
  - acnt == 0 → ADD; otherwise → ALIGN.
- ALIGN:
  - align_shift = 1 each cycle; acnt decrements.
  - Leave for ADD in the cycle acnt == 1, so exactly acnt shifts occur.
- ADD: add_en = 1, then → NCHK.
- NCHK (no strobes):
  - sum_zero → PACK with res_sel = 2.
  - msb_loc ≥ 27 (values 28–31 treated as 27) → NORM_R.
  - msb_loc == NORM_TARGET → ROUND.
  - Otherwise ncnt = NORM_TARGET - msb_loc, then → NORM_L.
- NORM_R: norm_right = 1 for one cycle, then → ROUND.
- NORM_L:
  - norm_left = 1 each cycle; ncnt decrements.
  - → ROUND in the cycle ncnt == 1.
  - msb_loc == 0 gives 26 cycles.
- ROUND: round_en = 1, then → RCHK.
- RCHK:
  - renorm_en = round_carry in the same cycle.
  - Then → PACK.
- PACK: pack_en = 1; res_sel held, 0 on the normal path. Then → DONE.
- DONE:
  - done = 1; busy = 1.
  - Then → IDLE; res_sel returns to 0.
- A new start is accepted in the cycle after DONE.
- Start while busy is ignored, not queued.
- Latency from the start edge to the done cycle:
  - Normal path: d + n + 7, where d = align shifts and n = 0, 1 or left-shift count.
  - Special path: 3.
  - Zero-sum path: d + 5.
- Status inputs are sampled only in their listed state; values at other times are ignored.

Optional Feature:
- Macro: FAST_ALIGN_EN.
- Defined: in UNPACK, exp_diff ≥ MAX_ALIGN → a single ALIGN cycle.
  - In that cycle align_flush (extra 1-bit output, port present only when the macro is defined) = 1 and align_shift = 0.
  - The datapath collapses the mantissa to sticky.
  - exp_diff < MAX_ALIGN behaves as in Behaviour.
- Undefined: no align_flush port; clamp to MAX_ALIGN one-bit shifts.

Test Plan:
- Reset, then start with special = 1 → ld_ops at cycle 0, pack_en at cycle 2, done at cycle 3, res_sel = 1 during PACK; no align/add/round strobes.
- exp_diff = 3, msb_loc = 26, round_carry = 0 → exactly 3 align_shift cycles; no norm or renorm strobes; done at cycle 10.
- exp_diff = 0, msb_loc = 27, round_carry = 1 → one norm_right, renorm_en in the RCHK cycle, done at cycle 8.
- exp_diff = 1, msb_loc = 20 → 6 norm_left cycles, done at cycle 14. Then exp_diff = 2, sum_zero = 1 → res_sel = 2 in PACK, done at cycle 7, no round_en.
- exp_diff = 200 → without FAST_ALIGN_EN, 27 align_shift cycles; with it, 1 align_flush cycle and 0 align_shift.
- Start pulses while busy are ignored. Deassert rst_n mid-ALIGN → all outputs 0 asynchronously, no done; a subsequent start completes normally.
